// File: rtl/uart_wb_host.sv
// Host end of the UART-to-Wishbone bridge: serialises read/write command
// frames to a byte transmitter and parses the response bytes from a receiver.
module uart_wb_host #(
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data
);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_RSP} state_t;

  state_t      state;
  logic        wr;
  logic [15:0] addr;
  logic [31:0] wdata;
  logic [2:0]  idx;
  logic [2:0]  next_idx;
  logic [2:0]  last_idx;
  logic [7:0]  next_byte;
  logic [1:0]  rx_cnt;
  logic [31:0] shreg;
  logic [31:0] word;
  logic [31:0] tmo;
  logic        done_rx;
  logic        timeout_hit;

  assign next_idx    = idx + 3'd1;
  assign last_idx    = wr ? 3'd6 : 3'd2;
  assign word        = {shreg[23:0], rx_data};
  assign done_rx     = rx_valid && (wr ? (rx_cnt == 2'd0) : (rx_cnt == 2'd3));
  assign timeout_hit = (tmo == TIMEOUT_CYC - 32'd1);

  // Byte 0 (opcode) is loaded at request acceptance; this supplies bytes 1..6.
  always_comb begin
    next_byte = '0;
    case (next_idx)
      3'd1:    next_byte = addr[15:8];
      3'd2:    next_byte = addr[7:0];
      3'd3:    next_byte = wdata[31:24];
      3'd4:    next_byte = wdata[23:16];
      3'd5:    next_byte = wdata[15:8];
      3'd6:    next_byte = wdata[7:0];
      default: next_byte = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      tx_valid  <= 1'b0;
      tx_data   <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      wr        <= 1'b0;
      addr      <= '0;
      wdata     <= '0;
      idx       <= '0;
      rx_cnt    <= '0;
      shreg     <= '0;
      tmo       <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            wr        <= req_write;
            addr      <= req_addr;
            wdata     <= req_wdata;
            idx       <= '0;
            tx_valid  <= 1'b1;
            tx_data   <= req_write ? 8'h01 : 8'h02;
            req_ready <= 1'b0;
            state     <= SEND;
          end
        end
        SEND: begin
          if (tx_ready) begin
            if (idx == last_idx) begin
              tx_valid <= 1'b0;
              rx_cnt   <= '0;
              tmo      <= '0;
              state    <= WAIT_RSP;
            end else begin
              idx     <= next_idx;
              tx_data <= next_byte;
            end
          end
        end
        WAIT_RSP: begin
          tmo <= tmo + 32'd1;
          if (rx_valid) begin
            shreg  <= word;
            rx_cnt <= rx_cnt + 2'd1;
          end
          // A completing byte wins over a timeout landing in the same cycle.
          if (done_rx) begin
            rsp_valid <= 1'b1;
            rsp_err   <= wr && (rx_data != 8'hA5);
            rsp_rdata <= wr ? '0 : word;
            req_ready <= 1'b1;
            state     <= IDLE;
          end else if (timeout_hit) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          req_ready <= 1'b1;
          tx_valid  <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_wb_host.sv
// Self-checking bench for uart_wb_host with a short response timeout.
module tb_uart_wb_host;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        rx_valid;
  logic [7:0]  rx_data;

  int checks   = 0;
  int failures = 0;

  uart_wb_host #(.TIMEOUT_CYC(TMO)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          ok;
    logic        first_valid;
    logic        ready_after;
    logic        tx_idle_after;
    int          ntx;
    logic [55:0] txv;
    int          tx_cycles;
    int          tx_errs;
    int          rsp_off;
    int          pulses;
    logic        err;
    logic [31:0] rd;
    logic        ready_at;
    logic        err_end;
    logic [31:0] rd_end;
  } obs_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: the response expected from the spec rules given the rx schedule
  // (offsets counted from the first cycle after the last byte is sent).
  task automatic model_rsp(input logic wr, input int n_rx, input int offs[4],
                           input logic [7:0] b[4], output int off,
                           output logic err, output logic [31:0] rd);
    int need;
    need = wr ? 1 : 4;
    if (n_rx >= need && offs[need-1] <= TMO - 1) begin
      off = offs[need-1] + 1;
      err = wr ? (b[0] != 8'hA5) : 1'b0;
      rd  = wr ? 32'h0 : {b[0], b[1], b[2], b[3]};
    end else begin
      off = TMO;
      err = 1'b1;
      rd  = 32'h0;
    end
  endtask

  function automatic logic [55:0] exp_frame(input logic wr, input logic [15:0] a,
                                            input logic [31:0] d);
    return wr ? {8'h01, a, d} : {32'h0, 8'h02, a};
  endfunction

  task automatic issue(input logic wr, input logic [15:0] a, input logic [31:0] d,
                       inout obs_t o);
    o.ok = 1'b0;
    for (int i = 0; i < 50 && !o.ok; i++) begin
      if (req_ready === 1'b1) o.ok = 1'b1;
      else tick();
    end
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
    tick();
    req_valid = 1'b0;
    req_write = 1'($urandom_range(0, 1));
    req_addr  = 16'($urandom);
    req_wdata = $urandom;
    o.first_valid = tx_valid;
    o.ready_after = req_ready;
  endtask

  // mode 0: tx_ready always 1; 1: toggles 1/0; 2: random.
  task automatic collect_tx(input int mode, input int n, input bit stray, inout obs_t o);
    logic       prev_stall;
    logic [7:0] prev_d;
    prev_stall  = 1'b0;
    prev_d      = '0;
    o.ntx       = 0;
    o.txv       = '0;
    o.tx_cycles = 0;
    o.tx_errs   = 0;
    while (o.ntx < n && o.tx_cycles < 200) begin
      tx_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (o.tx_cycles % 2 == 0)
                                                  : 1'($urandom_range(0, 1));
      rx_valid = stray && (o.tx_cycles == 1);
      rx_data  = 8'h77;
      if (tx_valid !== 1'b1) o.tx_errs++;
      if (prev_stall && tx_data !== prev_d) o.tx_errs++;
      prev_stall = tx_valid && !tx_ready;
      prev_d     = tx_data;
      if (tx_valid === 1'b1 && tx_ready) begin
        o.txv = {o.txv[47:0], tx_data};
        o.ntx++;
      end
      o.tx_cycles++;
      tick();
    end
    tx_ready = 1'b0;
    rx_valid = 1'b0;
    o.tx_idle_after = tx_valid;
  endtask

  task automatic wait_rsp(input int n_rx, input int offs[4], input logic [7:0] b[4],
                          inout obs_t o);
    o.rsp_off  = -1;
    o.pulses   = 0;
    o.err      = 1'b0;
    o.rd       = '0;
    o.ready_at = 1'b0;
    for (int k = 0; k < 40; k++) begin
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
      for (int j = 0; j < n_rx; j++) begin
        if (offs[j] == k) begin
          rx_valid = 1'b1;
          rx_data  = b[j];
        end
      end
      tick();
      if (rsp_valid === 1'b1) begin
        o.pulses++;
        if (o.rsp_off < 0) begin
          o.rsp_off  = k + 1;
          o.err      = rsp_err;
          o.rd       = rsp_rdata;
          o.ready_at = req_ready;
        end
      end
    end
    rx_valid = 1'b0;
    o.err_end = rsp_err;
    o.rd_end  = rsp_rdata;
  endtask

  task automatic run_txn(input logic wr, input logic [15:0] a, input logic [31:0] d,
                         input int mode, input bit stray, input int n_rx,
                         input int offs[4], input logic [7:0] b[4], output obs_t o);
    o = '{default: 0};
    issue(wr, a, d, o);
    collect_tx(mode, wr ? 7 : 3, stray, o);
    wait_rsp(n_rx, offs, b, o);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 1'b1;
    tx_ready = 1'b1;
    rx_valid = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    req_valid = 1'b0;
    tx_ready = 1'b0;
    rx_valid = 1'b0;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
    checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL reset_tx_valid got=%b exp=0", tx_valid); end
    checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL reset_tx_data got=%h exp=00", tx_data); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (rsp_err !== 1'b0) begin failures++; $display("FAIL reset_rsp_err got=%b exp=0", rsp_err); end
    checks++; if (rsp_rdata !== 32'h0) begin failures++; $display("FAIL reset_rsp_rdata got=%h exp=0", rsp_rdata); end
  endtask

  task automatic test_write_basic();
    obs_t o;
    run_txn(1'b1, 16'h1234, 32'hDEADBEEF, 0, 1'b0, 1, '{2, 0, 0, 0}, '{8'hA5, 0, 0, 0}, o);
    checks++; if (!o.ok) begin failures++; $display("FAIL wr_req_ready got=0 exp=1"); end
    checks++; if (o.first_valid !== 1'b1) begin failures++; $display("FAIL wr_first_valid got=%b exp=1", o.first_valid); end
    checks++; if (o.ready_after !== 1'b0) begin failures++; $display("FAIL wr_ready_busy got=%b exp=0", o.ready_after); end
    checks++; if (o.txv !== 56'h01_1234_DEADBEEF) begin failures++; $display("FAIL wr_tx_bytes got=%h exp=011234deadbeef", o.txv); end
    checks++; if (o.tx_cycles != 7 || o.tx_errs != 0) begin failures++; $display("FAIL wr_tx_timing got=%0d/%0d exp=7/0", o.tx_cycles, o.tx_errs); end
    checks++; if (o.tx_idle_after !== 1'b0) begin failures++; $display("FAIL wr_tx_drop got=%b exp=0", o.tx_idle_after); end
    checks++; if (o.rsp_off != 3 || o.pulses != 1) begin failures++; $display("FAIL wr_rsp_timing got=%0d/%0d exp=3/1", o.rsp_off, o.pulses); end
    checks++; if (o.err !== 1'b0 || o.rd !== 32'h0) begin failures++; $display("FAIL wr_rsp got=%b/%h exp=0/0", o.err, o.rd); end
    checks++; if (o.ready_at !== 1'b1) begin failures++; $display("FAIL wr_ready_at_rsp got=%b exp=1", o.ready_at); end
  endtask

  task automatic test_read_stall();
    obs_t o;
    run_txn(1'b0, 16'h0010, 32'h0, 1, 1'b0, 4, '{1, 2, 3, 4}, '{8'h11, 8'h22, 8'h33, 8'h44}, o);
    checks++; if (o.txv !== {32'h0, 24'h02_0010}) begin failures++; $display("FAIL rd_tx_bytes got=%h exp=020010", o.txv); end
    checks++; if (o.tx_cycles != 5 || o.tx_errs != 0) begin failures++; $display("FAIL rd_tx_stall got=%0d/%0d exp=5/0", o.tx_cycles, o.tx_errs); end
    checks++; if (o.rsp_off != 5 || o.pulses != 1) begin failures++; $display("FAIL rd_rsp_timing got=%0d/%0d exp=5/1", o.rsp_off, o.pulses); end
    checks++; if (o.err !== 1'b0 || o.rd !== 32'h11223344) begin failures++; $display("FAIL rd_rsp got=%b/%h exp=0/11223344", o.err, o.rd); end
  endtask

  task automatic test_bad_ack();
    obs_t o;
    run_txn(1'b1, 16'hBEEF, 32'h01020304, 0, 1'b0, 1, '{0, 0, 0, 0}, '{8'h5A, 0, 0, 0}, o);
    checks++; if (o.rsp_off != 1 || o.pulses != 1) begin failures++; $display("FAIL badack_timing got=%0d/%0d exp=1/1", o.rsp_off, o.pulses); end
    checks++; if (o.err !== 1'b1 || o.rd !== 32'h0) begin failures++; $display("FAIL badack_rsp got=%b/%h exp=1/0", o.err, o.rd); end
  endtask

  task automatic test_timeout();
    obs_t o;
    run_txn(1'b0, 16'h4000, 32'h0, 0, 1'b0, 0, '{0, 0, 0, 0}, '{0, 0, 0, 0}, o);
    checks++; if (o.rsp_off != TMO || o.pulses != 1) begin failures++; $display("FAIL tmo_timing got=%0d/%0d exp=%0d/1", o.rsp_off, o.pulses, TMO); end
    checks++; if (o.err !== 1'b1 || o.rd !== 32'h0) begin failures++; $display("FAIL tmo_rsp got=%b/%h exp=1/0", o.err, o.rd); end
    run_txn(1'b0, 16'h4004, 32'h0, 0, 1'b0, 4, '{3, 7, 11, TMO - 1}, '{8'hC0, 8'hFF, 8'hEE, 8'h01}, o);
    checks++; if (o.rsp_off != TMO || o.pulses != 1) begin failures++; $display("FAIL tmo_race_timing got=%0d/%0d exp=%0d/1", o.rsp_off, o.pulses, TMO); end
    checks++; if (o.err !== 1'b0 || o.rd !== 32'hC0FFEE01) begin failures++; $display("FAIL tmo_race_rsp got=%b/%h exp=0/c0ffee01", o.err, o.rd); end
  endtask

  task automatic test_stray();
    obs_t o;
    run_txn(1'b0, 16'h0020, 32'h0, 0, 1'b1, 4, '{0, 1, 2, 3}, '{8'hAA, 8'hBB, 8'hCC, 8'hDD}, o);
    checks++; if (o.rsp_off != 4 || o.pulses != 1) begin failures++; $display("FAIL stray_timing got=%0d/%0d exp=4/1", o.rsp_off, o.pulses); end
    checks++; if (o.err !== 1'b0 || o.rd !== 32'hAABBCCDD) begin failures++; $display("FAIL stray_rsp got=%b/%h exp=0/aabbccdd", o.err, o.rd); end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    int   tx_seen, rsp_seen;
    o = '{default: 0};
    issue(1'b1, 16'h5555, 32'h12345678, o);
    collect_tx(0, 2, 1'b0, o);
    checks++; if (o.txv[15:0] !== 16'h0155) begin failures++; $display("FAIL rstmid_first_bytes got=%h exp=0155", o.txv[15:0]); end
    rst = 1'b1;
    tx_ready = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (tx_valid !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("FAIL rstmid_state got=%b/%b exp=0/1", tx_valid, req_ready); end
    tx_seen = 0;
    rsp_seen = 0;
    for (int k = 0; k < 20; k++) begin
      if (tx_valid !== 1'b0) tx_seen++;
      if (rsp_valid !== 1'b0) rsp_seen++;
      rx_valid = (k == 3);
      rx_data  = 8'hA5;
      tick();
    end
    tx_ready = 1'b0;
    rx_valid = 1'b0;
    checks++; if (tx_seen != 0 || rsp_seen != 0) begin failures++; $display("FAIL rstmid_quiet got=%0d/%0d exp=0/0", tx_seen, rsp_seen); end
    run_txn(1'b0, 16'h0042, 32'h0, 0, 1'b0, 4, '{0, 2, 4, 6}, '{8'h01, 8'h23, 8'h45, 8'h67}, o);
    checks++; if (o.txv !== {32'h0, 24'h02_0042}) begin failures++; $display("FAIL rstmid_next_tx got=%h exp=020042", o.txv); end
    checks++; if (o.rsp_off != 7 || o.err !== 1'b0 || o.rd !== 32'h01234567) begin failures++; $display("FAIL rstmid_next_rsp got=%0d/%b/%h exp=7/0/01234567", o.rsp_off, o.err, o.rd); end
  endtask

  task automatic test_random();
    obs_t        o;
    logic        wr;
    logic [15:0] a;
    logic [31:0] d;
    int          mode, n_rx, need, t, e_off;
    int          offs[4];
    logic [7:0]  b[4];
    logic        e_err;
    logic [31:0] e_rd;
    bit          stray;
    for (int it = 0; it < 40; it++) begin
      wr    = 1'($urandom_range(0, 1));
      a     = 16'($urandom);
      d     = $urandom;
      mode  = $urandom_range(0, 2);
      stray = 1'($urandom_range(0, 1));
      need  = wr ? 1 : 4;
      n_rx  = ($urandom_range(0, 5) == 0) ? $urandom_range(0, need - 1) : need;
      t     = $urandom_range(0, 8);
      for (int j = 0; j < 4; j++) begin
        offs[j] = t;
        t += 1 + $urandom_range(0, 3);
        b[j] = 8'($urandom);
      end
      if (wr && $urandom_range(0, 2) != 0) b[0] = 8'hA5;
      model_rsp(wr, n_rx, offs, b, e_off, e_err, e_rd);
      run_txn(wr, a, d, mode, stray, n_rx, offs, b, o);
      checks++; if (o.txv !== exp_frame(wr, a, d) || o.tx_errs != 0) begin failures++; $display("FAIL rand%0d_tx got=%h/%0d exp=%h/0", it, o.txv, o.tx_errs, exp_frame(wr, a, d)); end
      checks++; if (o.rsp_off != e_off || o.pulses != 1) begin failures++; $display("FAIL rand%0d_timing got=%0d/%0d exp=%0d/1", it, o.rsp_off, o.pulses, e_off); end
      checks++; if (o.err !== e_err || o.rd !== e_rd) begin failures++; $display("FAIL rand%0d_rsp got=%b/%h exp=%b/%h", it, o.err, o.rd, e_err, e_rd); end
      checks++; if (o.err_end !== e_err || o.rd_end !== e_rd) begin failures++; $display("FAIL rand%0d_hold got=%b/%h exp=%b/%h", it, o.err_end, o.rd_end, e_err, e_rd); end
    end
  endtask

  initial begin
    rst       = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    tx_ready  = 1'b0;
    rx_valid  = 1'b0;
    rx_data   = '0;
    test_reset();
    test_write_basic();
    test_read_stall();
    test_bad_ack();
    test_timeout();
    test_stray();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_wb_host.md
UART_WB_HOST -- requirements
Module: uart_wb_host

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 1000000, giving the number of cycles to wait for a response before flagging an error.
REQ-002 SHALL have port clk  input  1  system clock; all logic is on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port req_valid  input  1  a command request is present.
REQ-005 SHALL have port req_ready  output  1  the block can accept a request.
REQ-006 SHALL have port req_write  input  1  1 = write, 0 = read.
REQ-007 SHALL have port req_addr  input  16  word address.
REQ-008 SHALL have port req_wdata  input  32  write data.
REQ-009 SHALL have port rsp_valid  output  1  one-cycle response strobe.
REQ-010 SHALL have port rsp_rdata  output  32  read data; 0 for writes and errors.
REQ-011 SHALL have port rsp_err  output  1  timeout or bad acknowledge, qualified by rsp_valid.
REQ-012 SHALL have port tx_valid  output  1  byte offered to the UART transmitter.
REQ-013 SHALL have port tx_data  output  8  byte to transmit.
REQ-014 SHALL have port tx_ready  input  1  the transmitter accepts a byte when tx_valid and tx_ready are both high.
REQ-015 SHALL have port rx_valid  input  1  one-cycle strobe for a byte received from the UART receiver.
REQ-016 SHALL have port rx_data  input  8  received byte.

Function
REQ-017 SHALL implement the host end of the UART-to-Wishbone bridge protocol; it issues command frames and parses response frames.
REQ-018 SHALL use the following frame formats, all multi-byte fields MSB first:
- write command: 0x01, addr[15:8], addr[7:0], wdata[31:24..7:0]; 7 bytes total.
- read command: 0x02, addr[15:8], addr[7:0]; 3 bytes total.
- write response: single byte 0xA5.
- read response: 4 data bytes.
REQ-019 SHALL implement a state machine with states IDLE, SEND and WAIT_RSP; rsp_valid pulses on the WAIT_RSP->IDLE transition cycle.
REQ-020 SHALL drive req_ready=1 only in IDLE.
REQ-021 SHALL, on the req_valid && req_ready cycle N:
- latch write, addr and wdata;
- clear the byte index;
- enter SEND, so that tx_valid=1 first appears at cycle N+1.
REQ-022 SHALL, in SEND:
- hold tx_valid=1 and tx_data = frame byte[index];
- keep tx_data stable while tx_ready=0;
- advance the index on each accepted byte.
REQ-023 SHALL, when the last frame byte is accepted, drop tx_valid the next cycle, enter WAIT_RSP, clear the response byte count and clear the timeout counter.
REQ-024 SHALL, in WAIT_RSP, shift each rx_data into a 32-bit register MSB first on rx_valid.
REQ-025 SHALL complete a read when the 4th byte arrives: rsp_rdata = the assembled word, rsp_err=0.
REQ-026 SHALL complete a write when its 1st byte arrives: rsp_rdata=0, and rsp_err=1 if the byte is not 0xA5, else rsp_err=0.
REQ-027 SHALL assert rsp_valid for exactly one cycle, in the cycle following the completing rx byte, and return to IDLE in that same cycle.
REQ-028 SHALL increment the timeout counter every cycle in WAIT_RSP without resetting it on received bytes; when it reaches TIMEOUT_CYC-1 without completion, SHALL pulse rsp_valid with rsp_err=1 and rsp_rdata=0, then go to IDLE.
REQ-029 SHALL give a completing rx byte priority over the timeout when both occur in the same cycle.
REQ-030 SHALL ignore rx_valid in IDLE and SEND; stray bytes are dropped and never counted.
REQ-031 SHALL hold rsp_rdata and rsp_err until the next rsp_valid.

Reset
REQ-032 SHALL, on rst=1 at a clock edge, enter IDLE and drive the following, effective from the next cycle:
- req_ready=1;
- tx_valid=0 and tx_data=0x00;
- rsp_valid=0, rsp_err=0 and rsp_rdata=0;
- all counters cleared.
REQ-033 SHALL, when rst is asserted mid-frame (SEND or WAIT_RSP), abandon the frame with no rsp_valid and send no remaining bytes.

Verification
REQ-034 SHALL cover a write with tx_ready always 1: addr 0x1234, wdata 0xDEADBEEF -> tx bytes 01 12 34 DE AD BE EF on 7 consecutive cycles; after rx 0xA5 -> rsp_valid=1, rsp_err=0, rsp_rdata=0.
REQ-035 SHALL cover a read at addr 0x0010 with tx_ready toggling 1/0 -> tx bytes 02 00 10, each held while stalled; after rx 11 22 33 44 -> rsp_rdata=0x11223344, rsp_err=0.
REQ-036 SHALL cover a bad acknowledge: a write answered with 0x5A -> rsp_valid with rsp_err=1.
REQ-037 SHALL cover timeouts with TIMEOUT_CYC=16:
- read with no rx -> rsp_err=1, rsp_rdata=0 exactly 16 cycles after entering WAIT_RSP;
- 4th rx byte arriving on the timeout cycle -> rsp_err=0.
REQ-038 SHALL cover a stray rx byte 0x77 during SEND -> ignored; a following read response AA BB CC DD -> rsp_rdata=0xAABBCCDD.
REQ-039 SHALL cover rst=1 after the 2nd tx byte of a write -> tx_valid=0 and req_ready=1 next cycle, with no rsp_valid; a subsequent request completes normally.
